// File: rtl/booth_multiplier_if.sv
// Start/operand/result bundle for the radix-4 Booth multiplier.
// The requester drives the master side and the multiplier sits on the slave side.
interface booth_multiplier_if #(
    parameter int WIDTH = 32
);
    logic               mult_begin;
    logic               mult_signed;
    logic [WIDTH-1:0]   operand1;
    logic [WIDTH-1:0]   operand2;
    logic [2*WIDTH-1:0] product;
    logic               mult_end;
    logic               busy;

    modport master (
        output mult_begin, mult_signed, operand1, operand2,
        input  product, mult_end, busy
    );

    modport slave (
        input  mult_begin, mult_signed, operand1, operand2,
        output product, mult_end, busy
    );
endinterface

// File: rtl/booth_multiplier.sv
// Sequential radix-4 Booth multiplier that retires one digit per clock.
// A level-held mult_begin starts the operation and keeps the result on display; dropping it aborts or releases.
module booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    booth_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH / 2 + 2);
    localparam logic [CW-1:0] ITERS = CW'(WIDTH / 2 + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] mcand;
    logic [WIDTH+3:0] acc;
    logic [WIDTH+1:0] mq;
    logic             qm1;

    logic [WIDTH+3:0] m_ext, sel, acc_sum, acc_nx;
    logic [WIDTH+1:0] mq_nx;
    logic             ext1, ext2;

    assign ext1  = bus.mult_signed & bus.operand1[WIDTH-1];
    assign ext2  = bus.mult_signed & bus.operand2[WIDTH-1];
    assign m_ext = {{2{mcand[WIDTH+1]}}, mcand};

    // Booth digit from {q[1], q[0], q[-1]} selects 0, +/-M or +/-2M.
    always_comb begin
        sel = '0;
        case ({mq[1:0], qm1})
            3'b001, 3'b010: sel = m_ext;
            3'b011:         sel = m_ext << 1;
            3'b100:         sel = -(m_ext << 1);
            3'b101, 3'b110: sel = -m_ext;
            default:        sel = '0;
        endcase
    end

    // {acc, mq} behaves as one long register shifted arithmetically by two each digit.
    assign acc_sum = acc + sel;
    assign acc_nx  = {{2{acc_sum[WIDTH+3]}}, acc_sum[WIDTH+3:2]};
    assign mq_nx   = {acc_sum[1:0], mq[WIDTH+1:2]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            mcand        <= '0;
            acc          <= '0;
            mq           <= '0;
            qm1          <= 1'b0;
            bus.product  <= '0;
            bus.mult_end <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mult_begin) begin
                        state    <= CALC;
                        bus.busy <= 1'b1;
                        cnt      <= ITERS;
                        mcand    <= {{2{ext1}}, bus.operand1};
                        mq       <= {{2{ext2}}, bus.operand2};
                        qm1      <= 1'b0;
                        acc      <= '0;
                    end
                end
                CALC: begin
                    if (!bus.mult_begin) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        acc <= acc_nx;
                        mq  <= mq_nx;
                        qm1 <= mq[1];
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            state        <= DONE;
                            bus.busy     <= 1'b0;
                            bus.mult_end <= 1'b1;
                            bus.product  <= {acc_nx[WIDTH-3:0], mq_nx};
                        end
                    end
                end
                DONE: begin
                    if (!bus.mult_begin) begin
                        state        <= IDLE;
                        bus.mult_end <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.busy     <= 1'b0;
                    bus.mult_end <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench: stimulus pushes hand-computed products into a queue, a monitor checks each mult_end rise.
module tb_booth_multiplier;
    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [2*W-1:0] exp_q[$];
    logic monitor_on = 1'b1;

    booth_multiplier_if #(.WIDTH(W)) bus ();
    booth_multiplier #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    function automatic void check(string name, logic [2*W-1:0] act, logic [2*W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Scoreboard monitor: every rising mult_end must match the oldest pending product.
    initial begin : monitor
        logic prev_end;
        logic [2*W-1:0] e;
        prev_end = 1'b0;
        while (monitor_on) begin
            @(negedge clk);
            if (bus.mult_end && !prev_end) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_mult_end", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("product", bus.product, e);
                end
            end
            prev_end = bus.mult_end;
        end
    end

    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(posedge clk); #1;
        bus.operand1    = a;
        bus.operand2    = b;
        bus.mult_signed = s;
        bus.mult_begin  = 1'b1;
    endtask

    // Returns the number of edges after the start edge until mult_end is seen, -1 on timeout.
    task automatic wait_end(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) check("busy_in_calc", 64'(bus.busy), 64'd1);
            if (bus.mult_end) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    task automatic drop();
        @(posedge clk); #1;
        bus.mult_begin = 1'b0;
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [2*W-1:0] e, input string name);
        int lat;
        go(a, b, s);
        exp_q.push_back(e);
        wait_end(lat);
        check({name, "_latency"}, 64'(lat), 64'd17);
        drop();
    endtask

    initial begin
        int lat;
        bus.mult_begin  = 1'b0;
        bus.mult_signed = 1'b0;
        bus.operand1    = '0;
        bus.operand2    = '0;

        // Async reset with no clock edge needed
        #1 resetn = 1'b0;
        #1;
        check("reset_product", bus.product, 64'd0);
        check("reset_mult_end", 64'(bus.mult_end), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        #20 resetn = 1'b1;

        // Unsigned max x max, hold mult_begin in DONE
        go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        exp_q.push_back(64'hFFFF_FFFE_0000_0001);
        wait_end(lat);
        check("umax_latency", 64'(lat), 64'd17);
        repeat (3) @(posedge clk);
        #1;
        check("hold_mult_end", 64'(bus.mult_end), 64'd1);
        check("hold_product", bus.product, 64'hFFFF_FFFE_0000_0001);
        drop();

        run(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, "s_m2x3");
        run(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_min_sq");
        run(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, "s_max_min");
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "s_m1_sq");
        run(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "u_msb_sq");
        run(32'h1234_5678, 32'h0000_0000, 1'b0, 64'h0,                  "u_zero");

        // 7x6 then release: mult_end falls on the next edge, product holds
        run(32'd7, 32'd6, 1'b0, 64'h2A, "u_7x6");
        @(posedge clk); #1;
        check("release_mult_end", 64'(bus.mult_end), 64'd0);
        check("release_busy", 64'(bus.busy), 64'd0);
        check("release_product", bus.product, 64'h2A);

        // 5x5 completes, 3x3 aborted at CALC cycle 8
        run(32'd5, 32'd5, 1'b0, 64'h19, "u_5x5");
        go(32'd3, 32'd3, 1'b0);
        repeat (8) @(posedge clk);
        #1 bus.mult_begin = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_product", bus.product, 64'h19);
        check("abort_mult_end", 64'(bus.mult_end), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);

        // Reset between edges during CALC
        go(32'd9, 32'd9, 1'b0);
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midcalc_rst_product", bus.product, 64'd0);
        check("midcalc_rst_mult_end", 64'(bus.mult_end), 64'd0);
        check("midcalc_rst_busy", 64'(bus.busy), 64'd0);
        bus.mult_begin = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle_busy", 64'(bus.busy), 64'd0);
        run(32'd2, 32'd2, 1'b0, 64'd4, "u_2x2");

        // Operand changes during CALC are ignored
        go(32'h10, 32'h10, 1'b0);
        exp_q.push_back(64'h100);
        repeat (3) @(posedge clk);
        #1;
        bus.operand1    = 32'hFFFF_0000;
        bus.operand2    = 32'h0F0F_0F0F;
        bus.mult_signed = 1'b1;
        wait_end(lat);
        check("opchg_latency", 64'(lat + 3), 64'd17);
        drop();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        monitor_on = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width, even, >= 4; product width is 2*WIDTH.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port mult_begin, input, 1: level-sensitive start/hold request (switch-driven).
REQ-005 SHALL have port mult_signed, input, 1: 1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have port operand1, input, WIDTH: multiplicand.
REQ-007 SHALL have port operand2, input, WIDTH: multiplier.
REQ-008 SHALL have port product, output, 2*WIDTH: registered result.
REQ-009 SHALL have port mult_end, output, 1: product valid; downstream latches product while high.
REQ-010 SHALL have port busy, output, 1: high while in CALC.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 IDLE: at an edge with mult_begin=1, SHALL latch operand1, operand2 and mult_signed, clear accumulator, load iteration counter with WIDTH/2+1, and go to CALC.
REQ-013 Latched operands SHALL be extended to WIDTH+2 bits: sign-extended when mult_signed=1, zero-extended otherwise.
REQ-014 CALC: each edge SHALL retire one radix-4 Booth digit (from multiplier bits 2i+1, 2i, 2i-1; bit -1 = 0).
- Digit selects 0, +/-M, or +/-2M.
- Arithmetic is in WIDTH+4-bit partial-sum width, with an arithmetic shift right by 2.
REQ-015 CALC SHALL last exactly WIDTH/2+1 edges (17 for WIDTH=32).
- On the last edge, product SHALL load the low 2*WIDTH bits of the final result and the state SHALL go to DONE.
REQ-016 Latency: mult_end SHALL be visible high after edge N+WIDTH/2+1, where N is the IDLE edge that sampled mult_begin=1.
REQ-017 DONE: mult_end=1 and product SHALL hold while mult_begin=1.
- At an edge with mult_begin=0: go to IDLE and clear mult_end.
- product SHALL retain its value.
REQ-018 After DONE->IDLE, a new multiplication SHALL start only at a later edge that samples mult_begin=1; back-to-back restart costs one IDLE cycle minimum.
REQ-019 mult_begin=0 sampled in CALC SHALL abort: go to IDLE, product unchanged, mult_end stays 0.
REQ-020 Changes on operand1/operand2/mult_signed outside the IDLE start edge SHALL NOT affect the result in progress.
REQ-021 product SHALL change only at the CALC->DONE edge or at reset.
REQ-022 busy SHALL be 1 exactly when state = CALC; mult_end SHALL be 1 exactly when state = DONE.
REQ-023 Results SHALL be exact modulo 2^(2*WIDTH) for all operand pairs in both modes, including most-negative operands.

Reset
REQ-024 resetn=0 SHALL immediately, without waiting for clk:
- set state to IDLE;
- clear product to 0, mult_end to 0 and busy to 0;
- clear counter, accumulator and latched operands.
REQ-025 Reset asserted during CALC or DONE SHALL discard the operation; no stale mult_end after release.
REQ-026 After resetn rises, the first start SHALL require an edge sampling mult_begin=1.

Verification
REQ-027 Unsigned 0xFFFFFFFF x 0xFFFFFFFF with mult_begin held -> product=0xFFFFFFFE_00000001 and mult_end high 17 cycles after the start edge.
REQ-028 Signed 0xFFFFFFFE (-2) x 0x00000003 -> product=0xFFFFFFFF_FFFFFFFA; signed 0x80000000 x 0x80000000 -> 0x40000000_00000000.
REQ-029 Unsigned 7 x 6, then drop mult_begin in DONE -> product holds 0x2A, mult_end falls on the next edge, busy=0.
REQ-030 Start 5 x 5 and complete, then start 3 x 3 and drop mult_begin at CALC cycle 8 -> IDLE, product stays 0x19, mult_end never rises.
REQ-031 Assert resetn=0 mid-CALC between clock edges -> product=0, mult_end=0, busy=0 immediately; after release, 2 x 2 completes to 4.
REQ-032 Change operand1 during CALC of 0x10 x 0x10 -> product=0x100 regardless.
